antirrebote_botones: RTL and testbench

ANTIRREBOTE_BOTONES -- requirements
Module: antirrebote_botones

---
 rtl/antirrebote_botones_pkg.sv | 24 ++
 rtl/antirrebote_canal.sv | 94 +++++++++
 rtl/antirrebote_botones.sv | 60 ++++++
 tb/tb_antirrebote_botones.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/antirrebote_botones_pkg.sv
// rtl/antirrebote_botones_pkg.sv - shared constants for the push-button debouncer
// Purpose: button index map into the 5-bit {L,C,U,D,R} vectors, channel count,
//          default debounce length and the counter width helper.
// Ports:   none (package)
package antirrebote_botones_pkg;

   localparam int NUM_BTN = 5;

   // Bit positions inside press_pulse and the internal raw/level vectors
   localparam int BTN_L = 4;
   localparam int BTN_C = 3;
   localparam int BTN_U = 2;
   localparam int BTN_D = 1;
   localparam int BTN_R = 0;

   // Stable samples needed to accept a new level (10 ms at 100 MHz)
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

   // Counter width: it only has to reach DEBOUNCE_CYCLES-1, never DEBOUNCE_CYCLES
   function automatic int cnt_width(input int unsigned cycles);
      return $clog2(cycles);
   endfunction

endpackage

// File: rtl/antirrebote_canal.sv
// rtl/antirrebote_canal.sv - single debounced push-button channel
// Purpose: two-flop synchronizer, stability counter, debounced level, one-cycle
//          press strobe and (with BTN_TOGGLE_EN defined) a latched toggle output.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   raw    in   asynchronous raw button level, active-high
//   level  out  clean level (db, or toggle state when BTN_TOGGLE_EN is defined)
//   pulse  out  one-cycle strobe after each accepted 0->1 of db
// Configuration macro: BTN_TOGGLE_EN
module antirrebote_canal
   import antirrebote_botones_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic pulse
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_q1;
   logic          sync_q2;
   logic          db;
   logic          db_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          rise;
   logic          pulse_q;

   // Only sync_q2 is ever looked at by the counter logic
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= raw;
         sync_q2 <= sync_q1;
      end
   end

   // Any sample matching db restarts the count, so a glitch never accumulates.
   // The flip happens on the edge the counter would have reached
   // DEBOUNCE_CYCLES, hence the counter never needs that value.
   always_comb begin
      db_next  = db;
      cnt_next = '0;
      rise     = 1'b0;
      if (sync_q2 != db) begin
         if (cnt == CNT_MAX) begin
            db_next = ~db;
            rise    = ~db;
         end else begin
            cnt_next = cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db      <= 1'b0;
         cnt     <= '0;
         pulse_q <= 1'b0;
      end else begin
         db      <= db_next;
         cnt     <= cnt_next;
         pulse_q <= rise;
      end
   end

   assign pulse = pulse_q;

`ifdef BTN_TOGGLE_EN
   logic toggle_q;

   // Flips on the same edge that raises the strobe, so it changes together with db
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         toggle_q <= 1'b0;
      end else if (rise) begin
         toggle_q <= ~toggle_q;
      end
   end

   assign level = toggle_q;
`else
   assign level = db;
`endif

endmodule

// File: rtl/antirrebote_botones.sv
// rtl/antirrebote_botones.sv - five-button debouncer for the board push-buttons
// Purpose: debounces L, C, U, D, R independently and provides clean levels plus
//          accepted-press strobes for the input-processing stage.
// Ports:
//   clk                  in   system clock, rising edge
//   rst_n                in   asynchronous active-low reset (release synchronous upstream)
//   btnL_raw..btnR_raw   in   raw asynchronous button levels, active-high
//   btnL..btnR           out  clean levels (toggle state with BTN_TOGGLE_EN)
//   press_pulse[4:0]     out  one-cycle press strobes, {L,C,U,D,R}
// Configuration macro: BTN_TOGGLE_EN (handled inside each channel)
module antirrebote_botones
   import antirrebote_botones_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               btnL_raw,
   input  logic               btnC_raw,
   input  logic               btnU_raw,
   input  logic               btnD_raw,
   input  logic               btnR_raw,
   output logic               btnL,
   output logic               btnC,
   output logic               btnU,
   output logic               btnD,
   output logic               btnR,
   output logic [NUM_BTN-1:0] press_pulse
);

   logic [NUM_BTN-1:0] raw;
   logic [NUM_BTN-1:0] level;
   logic [NUM_BTN-1:0] pulse;

   assign raw[BTN_L] = btnL_raw;
   assign raw[BTN_C] = btnC_raw;
   assign raw[BTN_U] = btnU_raw;
   assign raw[BTN_D] = btnD_raw;
   assign raw[BTN_R] = btnR_raw;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_canal
      antirrebote_canal #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_canal (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (raw[i]),
         .level (level[i]),
         .pulse (pulse[i])
      );
   end

   assign btnL        = level[BTN_L];
   assign btnC        = level[BTN_C];
   assign btnU        = level[BTN_U];
   assign btnD        = level[BTN_D];
   assign btnR        = level[BTN_R];
   assign press_pulse = pulse;

endmodule

// File: tb/tb_antirrebote_botones.sv
// tb/tb_antirrebote_botones.sv - directed bench for antirrebote_botones with DEBOUNCE_CYCLES=4
module tb_antirrebote_botones;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btnL_raw = 1'b0, btnC_raw = 1'b0, btnU_raw = 1'b0, btnD_raw = 1'b0, btnR_raw = 1'b0;
   logic       btnL, btnC, btnU, btnD, btnR;
   logic [4:0] press_pulse;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   antirrebote_botones #(.DEBOUNCE_CYCLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btnL_raw    (btnL_raw),
      .btnC_raw    (btnC_raw),
      .btnU_raw    (btnU_raw),
      .btnD_raw    (btnD_raw),
      .btnR_raw    (btnR_raw),
      .btnL        (btnL),
      .btnC        (btnC),
      .btnU        (btnU),
      .btnD        (btnD),
      .btnR        (btnR),
      .press_pulse (press_pulse)
   );

   // Advance one rising edge; sample and drive 1 ns after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      n_tests++;
      if ({btnL, btnC, btnU, btnD, btnR} !== 5'b00000) begin
         n_fail++;
         $display("FAIL reset_levels got=%b exp=%b", {btnL, btnC, btnU, btnD, btnR}, 5'b00000);
      end
      n_tests++;
      if (press_pulse !== 5'b00000) begin
         n_fail++;
         $display("FAIL reset_pulse got=%b exp=%b", press_pulse, 5'b00000);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_press();
      logic [4:0] exp_lv;
      logic [4:0] exp_p;
      btnC_raw = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         step();
         exp_lv = (i >= 6) ? 5'b01000 : 5'b00000;
         exp_p  = (i == 6) ? 5'b01000 : 5'b00000;
         n_tests++;
         if ({btnL, btnC, btnU, btnD, btnR} !== exp_lv) begin
            n_fail++;
            $display("FAIL single_level edge=%0d got=%b exp=%b", i, {btnL, btnC, btnU, btnD, btnR}, exp_lv);
         end
         n_tests++;
         if (press_pulse !== exp_p) begin
            n_fail++;
            $display("FAIL single_pulse edge=%0d got=%b exp=%b", i, press_pulse, exp_p);
         end
      end
      btnC_raw = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         step();
         n_tests++;
         if (press_pulse !== 5'b00000) begin
            n_fail++;
            $display("FAIL single_release_pulse edge=%0d got=%b exp=%b", i, press_pulse, 5'b00000);
         end
      end
      n_tests++;
`ifdef BTN_TOGGLE_EN
      if (btnC !== 1'b1) begin
         n_fail++;
         $display("FAIL single_release_level got=%b exp=%b", btnC, 1'b1);
      end
`else
      if (btnC !== 1'b0) begin
         n_fail++;
         $display("FAIL single_release_level got=%b exp=%b", btnC, 1'b0);
      end
`endif
   endtask

   task automatic test_glitch();
      logic [8:0] pat;
      pat = 9'b110110110;
      for (int i = 0; i < 17; i++) begin
         btnU_raw = (i < 9) ? pat[8 - i] : 1'b0;
         step();
         n_tests++;
         if (btnU !== 1'b0 || press_pulse !== 5'b00000) begin
            n_fail++;
            $display("FAIL glitch step=%0d btnU=%b pulse=%b exp btnU=0 pulse=00000", i, btnU, press_pulse);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [4:0] exp_p;
      logic       exp_lv;
      btnL_raw = 1'b1;
      btnR_raw = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         step();
         exp_p  = (i == 6) ? 5'b10001 : 5'b00000;
         exp_lv = (i >= 6);
         n_tests++;
         if (press_pulse !== exp_p) begin
            n_fail++;
            $display("FAIL simul_pulse edge=%0d got=%b exp=%b", i, press_pulse, exp_p);
         end
         n_tests++;
         if (btnL !== exp_lv || btnR !== exp_lv) begin
            n_fail++;
            $display("FAIL simul_level edge=%0d got L=%b R=%b exp=%b", i, btnL, btnR, exp_lv);
         end
      end
      btnL_raw = 1'b0;
      btnR_raw = 1'b0;
      for (int i = 1; i <= 8; i++) step();
      n_tests++;
`ifdef BTN_TOGGLE_EN
      if (btnL !== 1'b1 || btnR !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_release got L=%b R=%b exp=1", btnL, btnR);
      end
`else
      if (btnL !== 1'b0 || btnR !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_release got L=%b R=%b exp=0", btnL, btnR);
      end
`endif
   endtask

   task automatic test_release();
      logic exp_lv;
      btnD_raw = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         n_tests++;
         if (press_pulse !== ((i == 6) ? 5'b00010 : 5'b00000)) begin
            n_fail++;
            $display("FAIL release_press_pulse edge=%0d got=%b", i, press_pulse);
         end
      end
      btnD_raw = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         step();
`ifdef BTN_TOGGLE_EN
         exp_lv = 1'b1;
`else
         exp_lv = (i < 6);
`endif
         n_tests++;
         if (btnD !== exp_lv) begin
            n_fail++;
            $display("FAIL release_level edge=%0d got=%b exp=%b", i, btnD, exp_lv);
         end
         n_tests++;
         if (press_pulse !== 5'b00000) begin
            n_fail++;
            $display("FAIL release_pulse edge=%0d got=%b exp=%b", i, press_pulse, 5'b00000);
         end
      end
   endtask

   task automatic test_reset_mid();
      btnC_raw = 1'b1;
      step();
      step();
      step();
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({btnL, btnC, btnU, btnD, btnR, press_pulse} !== 10'b0) begin
         n_fail++;
         $display("FAIL reset_mid_async got lv=%b pulse=%b exp=0", {btnL, btnC, btnU, btnD, btnR}, press_pulse);
      end
      step();
      step();
      rst_n = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         n_tests++;
         if (btnC !== (i >= 6)) begin
            n_fail++;
            $display("FAIL reset_mid_level edge=%0d got=%b exp=%b", i, btnC, (i >= 6));
         end
         n_tests++;
         if (press_pulse !== ((i == 6) ? 5'b01000 : 5'b00000)) begin
            n_fail++;
            $display("FAIL reset_mid_pulse edge=%0d got=%b", i, press_pulse);
         end
      end
      btnC_raw = 1'b0;
      for (int i = 1; i <= 8; i++) step();
   endtask

   task automatic test_toggle();
      logic [3:0] exp_seq;
      int         pulses;
`ifdef BTN_TOGGLE_EN
      exp_seq = 4'b1100;
`else
      exp_seq = 4'b1010;
`endif
      for (int ph = 0; ph < 4; ph++) begin
         btnR_raw = (ph % 2 == 0);
         pulses = 0;
         for (int i = 1; i <= 8; i++) begin
            step();
            if (press_pulse[0] === 1'b1) pulses++;
         end
         n_tests++;
         if (btnR !== exp_seq[3 - ph]) begin
            n_fail++;
            $display("FAIL toggle_level phase=%0d got=%b exp=%b", ph, btnR, exp_seq[3 - ph]);
         end
         n_tests++;
         if (pulses !== ((ph % 2 == 0) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL toggle_pulses phase=%0d got=%0d exp=%0d", ph, pulses, (ph % 2 == 0) ? 1 : 0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_glitch();
      test_simultaneous();
      test_release();
      test_reset_mid();
      test_toggle();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
